uart_rx_sampler: RTL and testbench

Front end of the UART receive path, directly upstream of the deserializer. It watches the asynchronous `rx_in` line (already synchronised), detects the start bit and times each bit by oversampling at `prescale` clocks per bit. At mid-bit it takes a 3-sample majority vote. It then drives `sampeled_bit`, `deserializer_en` and `bit_cnt` in exactly the form the deserializer consumes, plus strobes for the parity and stop checkers.

---
 rtl/uart_rx_sampler.sv | 194 +++++++++++++++++++
 tb/tb_uart_rx_sampler.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: start detection, oversampled bit timing and 3-sample
// majority vote for the UART receive path. Emits the voted bit plus the
// field index and strobes consumed by the deserializer, parity and stop
// checkers.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | line watched for a low level while rx_en is set
// START  | timing the start bit; a voted 1 is a false start
// DATA   | timing data bits 1..DATA_WIDTH, one deserializer_en per bit
// PARITY | timing the parity bit (only when par_en was latched high)
// STOP   | timing the stop bit; leaves one cycle after its vote
module uart_rx_sampler #(
   parameter int DATA_WIDTH = 8
) (
   input  logic       clck,
   input  logic       rst,
   input  logic       rx_in,
   input  logic       rx_en,
   input  logic [5:0] prescale,
   input  logic       par_en,
   output logic       sampeled_bit,
   output logic       deserializer_en,
   output logic [4:0] bit_cnt,
   output logic       par_valid,
   output logic       stop_valid,
   output logic       stop_err,
   output logic       start_glitch,
   output logic       busy
);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   localparam logic [4:0] LAST_DATA = 5'(DATA_WIDTH);
   localparam logic [4:0] PAR_IDX   = 5'(DATA_WIDTH + 1);

   state_t     state_q;
   logic [4:0] edge_cnt_q;
   logic [4:0] bit_cnt_q;
   logic [1:0] psel_q;
   logic [1:0] psel_d;
   logic       par_en_q;
   logic       samp0_q;
   logic       samp1_q;
   logic       sampeled_bit_q;
   logic       deser_en_q;
   logic       par_valid_q;
   logic       stop_valid_q;
   logic       stop_err_q;
   logic       start_glitch_q;
   logic       busy_q;

   logic [4:0] edge_last;
   logic [4:0] edge_mid;
   logic       vote;
   logic       at_mid;
   logic       at_report;
   logic       at_wrap;

   // Map the prescale input to a ratio select; unsupported ratios run at 16.
   always_comb begin
      psel_d = 2'd1;
      case (prescale)
         6'd8:    psel_d = 2'd0;
         6'd32:   psel_d = 2'd2;
         default: psel_d = 2'd1;
      endcase
   end

   // Per-ratio wrap point and mid-bit sample point for the latched ratio.
   always_comb begin
      edge_last = 5'd15;
      edge_mid  = 5'd8;
      case (psel_q)
         2'd0: begin
            edge_last = 5'd7;
            edge_mid  = 5'd4;
         end
         2'd2: begin
            edge_last = 5'd31;
            edge_mid  = 5'd16;
         end
         default: begin
            edge_last = 5'd15;
            edge_mid  = 5'd8;
         end
      endcase
   end

   // The third sample is the live line at the mid point, so the vote is ready
   // in the same cycle and registered at the edge that ends it.
   assign vote      = (samp0_q & samp1_q) | (samp0_q & rx_in) | (samp1_q & rx_in);
   assign at_mid    = (edge_cnt_q == edge_mid);
   assign at_report = (edge_cnt_q == edge_mid + 5'd1);
   assign at_wrap   = (edge_cnt_q == edge_last);

   // Receive FSM with bit timer, sample capture and registered strobes.
   always_ff @(posedge clck) begin
      if (rst) begin
         state_q        <= IDLE;
         edge_cnt_q     <= 5'd0;
         bit_cnt_q      <= 5'd0;
         psel_q         <= 2'd1;
         par_en_q       <= 1'b0;
         samp0_q        <= 1'b1;
         samp1_q        <= 1'b1;
         sampeled_bit_q <= 1'b1;
         deser_en_q     <= 1'b0;
         par_valid_q    <= 1'b0;
         stop_valid_q   <= 1'b0;
         stop_err_q     <= 1'b0;
         start_glitch_q <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         deser_en_q     <= 1'b0;
         par_valid_q    <= 1'b0;
         stop_valid_q   <= 1'b0;
         stop_err_q     <= 1'b0;
         start_glitch_q <= 1'b0;
         if (!rx_en) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            edge_cnt_q <= 5'd0;
            bit_cnt_q  <= 5'd0;
         end else if (state_q == IDLE) begin
            edge_cnt_q <= 5'd0;
            if (!rx_in) begin
               // The detection cycle itself counts as edge 0.
               state_q    <= START;
               busy_q     <= 1'b1;
               edge_cnt_q <= 5'd1;
               bit_cnt_q  <= 5'd0;
               par_en_q   <= par_en;
               psel_q     <= psel_d;
            end
         end else begin
            edge_cnt_q <= at_wrap ? 5'd0 : edge_cnt_q + 5'd1;
            if (edge_cnt_q == edge_mid - 5'd2) samp0_q <= rx_in;
            if (edge_cnt_q == edge_mid - 5'd1) samp1_q <= rx_in;
            if (at_mid) begin
               sampeled_bit_q <= vote;
               case (state_q)
                  START:   start_glitch_q <= vote;
                  DATA:    deser_en_q     <= 1'b1;
                  PARITY:  par_valid_q    <= 1'b1;
                  STOP: begin
                     stop_valid_q <= 1'b1;
                     stop_err_q   <= ~vote;
                  end
                  default: ;
               endcase
            end
            // Stop leaves right after its vote so a start edge in the second
            // half of the stop bit is not missed.
            if (at_report && (state_q == STOP || (state_q == START && sampeled_bit_q))) begin
               state_q    <= IDLE;
               busy_q     <= 1'b0;
               edge_cnt_q <= 5'd0;
            end else if (at_wrap) begin
               case (state_q)
                  START: begin
                     state_q   <= DATA;
                     bit_cnt_q <= 5'd1;
                  end
                  DATA: begin
                     if (bit_cnt_q == LAST_DATA) begin
                        if (par_en_q) begin
                           state_q   <= PARITY;
                           bit_cnt_q <= PAR_IDX;
                        end else begin
                           state_q <= STOP;
                        end
                     end else begin
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                     end
                  end
                  PARITY:  state_q <= STOP;
                  default: ;
               endcase
            end
         end
      end
   end

   assign sampeled_bit    = sampeled_bit_q;
   assign deserializer_en = deser_en_q;
   assign bit_cnt         = bit_cnt_q;
   assign par_valid       = par_valid_q;
   assign stop_valid      = stop_valid_q;
   assign stop_err        = stop_err_q;
   assign start_glitch    = start_glitch_q;
   assign busy            = busy_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler: frames are driven bit by bit, the
// expected strobes (kind, cycle, index, value) are queued at frame start and
// matched in order as the DUT emits them.
module tb_uart_rx_sampler;

   localparam int DW       = 8;
   localparam int K_DATA   = 0;
   localparam int K_PAR    = 1;
   localparam int K_STOP   = 2;
   localparam int K_GLITCH = 3;
   localparam int NO_STOP  = 1 << 30;

   logic       clck = 1'b0;
   logic       rst;
   logic       rx_in;
   logic       rx_en;
   logic [5:0] prescale;
   logic       par_en;
   logic       sampeled_bit;
   logic       deserializer_en;
   logic [4:0] bit_cnt;
   logic       par_valid;
   logic       stop_valid;
   logic       stop_err;
   logic       start_glitch;
   logic       busy;

   typedef struct {
      int   kind;
      int   cyc;
      int   bc;
      logic bitv;
      logic err;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   exp_t mon_e;
   int   mon_kind;

   uart_rx_sampler #(.DATA_WIDTH(DW)) dut (
      .clck            (clck),
      .rst             (rst),
      .rx_in           (rx_in),
      .rx_en           (rx_en),
      .prescale        (prescale),
      .par_en          (par_en),
      .sampeled_bit    (sampeled_bit),
      .deserializer_en (deserializer_en),
      .bit_cnt         (bit_cnt),
      .par_valid       (par_valid),
      .stop_valid      (stop_valid),
      .stop_err        (stop_err),
      .start_glitch    (start_glitch),
      .busy            (busy)
   );

   always #5 clck = ~clck;

   always @(posedge clck) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_deser_en"}, deserializer_en, 0);
      chk({tag, "_par_valid"}, par_valid, 0);
      chk({tag, "_stop_valid"}, stop_valid, 0);
      chk({tag, "_stop_err"}, stop_err, 0);
      chk({tag, "_start_glitch"}, start_glitch, 0);
      chk({tag, "_bit_cnt"}, bit_cnt, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   // Drive one frame field by field; expectations for strobes that land at or
   // before offset stop_at are queued. Returns early at offset stop_at.
   task automatic send_frame(input logic [15:0] data, input int p, input bit par,
                             input bit parbit, input bit stopbit,
                             input int glitch_field, input int stop_at);
      int   nf;
      int   d;
      int   off;
      logic lvl;
      exp_t e;
      nf = DW + 2 + (par ? 1 : 0);
      d  = cyc;
      for (int i = 1; i <= DW; i++) begin
         off = i * p + p / 2 + 1;
         e.kind = K_DATA; e.cyc = d + off; e.bc = i; e.bitv = data[i-1]; e.err = 1'b0;
         if (off <= stop_at) sb.push_back(e);
      end
      if (par) begin
         off = (DW + 1) * p + p / 2 + 1;
         e.kind = K_PAR; e.cyc = d + off; e.bc = DW + 1; e.bitv = parbit; e.err = 1'b0;
         if (off <= stop_at) sb.push_back(e);
      end
      off = (nf - 1) * p + p / 2 + 1;
      e.kind = K_STOP; e.cyc = d + off; e.bc = 0; e.bitv = stopbit; e.err = ~stopbit;
      if (off <= stop_at) sb.push_back(e);
      par_en = par;
      for (int f = 0; f < nf; f++) begin
         for (int c = 0; c < p; c++) begin
            if (f * p + c >= stop_at) return;
            if (f == 0)                lvl = 1'b0;
            else if (f <= DW)          lvl = data[f-1];
            else if (par && f == DW+1) lvl = parbit;
            else                       lvl = stopbit;
            if (f == glitch_field && c == p / 2 - 1) lvl = ~lvl;
            if (f == nf - 1 && c > p / 2 + 1) lvl = 1'b1;
            rx_in = lvl;
            @(negedge clck);
            // par_en must have been latched at detection.
            if (f == 0 && c == 0) par_en = ~par;
         end
      end
      rx_in = 1'b1;
   endtask

   // Match every emitted strobe against the head of the scoreboard.
   always @(negedge clck) begin
      if ((deserializer_en | par_valid | stop_valid | start_glitch) === 1'b1) begin
         chk("strobe_onehot", $countones({deserializer_en, par_valid, stop_valid, start_glitch}), 1);
         if (deserializer_en)  mon_kind = K_DATA;
         else if (par_valid)   mon_kind = K_PAR;
         else if (stop_valid)  mon_kind = K_STOP;
         else                  mon_kind = K_GLITCH;
         chk("strobe_expected", sb.size() != 0, 1);
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("strobe_kind", mon_kind, mon_e.kind);
            chk("strobe_cycle", cyc, mon_e.cyc);
            if (mon_e.kind != K_STOP) chk("strobe_bit_cnt", bit_cnt, mon_e.bc);
            chk("strobe_sampeled_bit", sampeled_bit, mon_e.bitv);
            if (mon_e.kind == K_STOP) chk("strobe_stop_err", stop_err, mon_e.err);
         end
      end
   end

   initial begin : stim
      int   d;
      exp_t g;
      rst = 1'b1; rx_en = 1'b1; rx_in = 1'b1; par_en = 1'b0; prescale = 6'd8;
      repeat (3) @(negedge clck);
      chk_quiet("reset");
      chk("reset_sampeled_bit", sampeled_bit, 1);
      rst = 1'b0;
      @(negedge clck);

      // Disabled receiver ignores a low line.
      rx_en = 1'b0; rx_in = 1'b0;
      repeat (3) @(negedge clck);
      chk("disabled_busy", busy, 0);
      rx_in = 1'b1; rx_en = 1'b1;
      @(negedge clck);

      // P=8, no parity, 0xA5, good stop.
      prescale = 6'd8;
      send_frame(16'h00A5, 8, 1'b0, 1'b0, 1'b1, -1, NO_STOP);
      repeat (4) @(negedge clck);
      chk("a5_all_seen", sb.size(), 0);
      chk("a5_busy_idle", busy, 0);

      // P=16, parity on, 0x3C, parity 0, bad stop.
      prescale = 6'd16;
      send_frame(16'h003C, 16, 1'b1, 1'b0, 1'b0, -1, NO_STOP);
      repeat (4) @(negedge clck);
      chk("3c_all_seen", sb.size(), 0);
      chk("3c_busy_idle", busy, 0);

      // P=16 false start: line low for 4 clocks.
      d = cyc;
      g.kind = K_GLITCH; g.cyc = d + 9; g.bc = 0; g.bitv = 1'b1; g.err = 1'b0;
      sb.push_back(g);
      rx_in = 1'b0;
      repeat (4) @(negedge clck);
      rx_in = 1'b1;
      repeat (5) @(negedge clck);
      chk("glitch_busy_at_vote", busy, 1);
      @(negedge clck);
      chk("glitch_busy_after", busy, 0);
      repeat (30) @(negedge clck);
      chk("glitch_all_seen", sb.size(), 0);

      // Unsupported ratio runs at 16; bit 3 has its middle sample flipped.
      prescale = 6'd20;
      send_frame(16'h0008, 16, 1'b0, 1'b0, 1'b1, 4, NO_STOP);
      repeat (4) @(negedge clck);
      chk("vote_all_seen", sb.size(), 0);

      // P=32 back-to-back 0x55 frames, one idle clock between.
      prescale = 6'd32;
      send_frame(16'h0055, 32, 1'b0, 1'b0, 1'b1, -1, NO_STOP);
      @(negedge clck);
      send_frame(16'h0055, 32, 1'b0, 1'b0, 1'b1, -1, NO_STOP);
      repeat (4) @(negedge clck);
      chk("b2b_all_seen", sb.size(), 0);

      // Abort via rx_en during bit 5.
      prescale = 6'd16;
      send_frame(16'h00FF, 16, 1'b0, 1'b0, 1'b1, -1, 5 * 16 + 3);
      chk("abort_pre_bit_cnt", bit_cnt, 5);
      rx_en = 1'b0;
      @(negedge clck);
      rx_in = 1'b1;
      chk_quiet("abort");
      repeat (40) @(negedge clck);
      chk("abort_busy_later", busy, 0);
      rx_en = 1'b1;
      repeat (4) @(negedge clck);
      chk("abort_all_seen", sb.size(), 0);

      // Synchronous reset during bit 5 of an all-zero frame.
      send_frame(16'h0000, 16, 1'b0, 1'b0, 1'b1, -1, 5 * 16 + 3);
      chk("rstmid_pre_sampeled_bit", sampeled_bit, 0);
      rst = 1'b1;
      @(negedge clck);
      chk_quiet("rstmid");
      chk("rstmid_sampeled_bit", sampeled_bit, 1);
      rst = 1'b0; rx_in = 1'b1;
      repeat (40) @(negedge clck);
      chk("rstmid_busy_later", busy, 0);
      chk("rstmid_all_seen", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
